// File: rtl/dcm_monitor.sv
// dcm_monitor: samples the divided clock as data in the source clock domain,
// measures each rise-to-rise period and its high time, and tracks lock/error
// status against the period implied by the current program code.
module dcm_monitor #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic [2:0]       prog,
  input  logic             update,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  localparam int unsigned MC_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic             d_q;
  logic [2:0]       prog_q;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] hi_q, hi_n;
  logic [MC_W-1:0]  match_q, match_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, locked_n, err_n;

  logic             rise_c;
  logic             resync_c;
  logic [CNT_W-1:0] exp_h_c;
  logic [CNT_W-1:0] exp_p_c;
  logic             match_c;

  // Expected half period for a program code; code 0 is bypass (no measurement).
  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] p);
    case (p)
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      3'd3:    return CNT_W'(5);
      3'd4:    return CNT_W'(8);
      3'd5:    return CNT_W'(16);
      3'd6:    return CNT_W'(32);
      3'd7:    return CNT_W'(64);
      default: return '0;
    endcase
  endfunction

  assign rise_c   = div_in & ~d_q;
  assign resync_c = update | (prog != prog_q);
  assign exp_h_c  = half_period(prog_q);
  assign exp_p_c  = exp_h_c + exp_h_c;
  assign match_c  = (cnt_q == exp_p_c) && (hi_q == exp_h_c);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= 1'b0;
      prog_q    <= 3'd0;
      cnt_q     <= '0;
      hi_q      <= '0;
      match_q   <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      d_q       <= div_in;
      prog_q    <= prog;
      cnt_q     <= cnt_n;
      hi_q      <= hi_n;
      match_q   <= match_n;
      period    <= period_n;
      high_time <= high_n;
      valid     <= valid_n;
      locked    <= locked_n;
      err       <= err_n;
    end
  end

  // Next-state, measurement and lock/error decisions.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    hi_n     = hi_q;
    match_n  = match_q;
    period_n = period;
    high_n   = high_time;
    valid_n  = 1'b0;
    locked_n = locked;
    err_n    = err;

    if (state_q == IDLE) begin
      locked_n = 1'b0;
      err_n    = 1'b0;
      match_n  = '0;
      if (prog != 3'd0) begin
        state_n = WAIT_EDGE;
      end
    end else if (resync_c) begin
      // Resync beats any rise or timeout seen in the same cycle.
      locked_n = 1'b0;
      err_n    = 1'b0;
      match_n  = '0;
      state_n  = (prog == 3'd0) ? IDLE : WAIT_EDGE;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          if (rise_c) begin
            cnt_n   = CNT_W'(1);
            hi_n    = CNT_W'(1);
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            period_n = cnt_q;
            high_n   = hi_q;
            valid_n  = 1'b1;
            cnt_n    = CNT_W'(1);
            hi_n     = CNT_W'(1);
            if (match_c) begin
              if (match_q != LOCK_TGT) begin
                match_n = match_q + MC_W'(1);
              end
              locked_n = (match_n == LOCK_TGT);
            end else begin
              if (locked) begin
                err_n = 1'b1;
              end
              locked_n = 1'b0;
              match_n  = '0;
            end
          end else if (cnt_q == CNT_MAX) begin
            // No rise within the counter range: the divided clock has stalled.
            err_n    = 1'b1;
            locked_n = 1'b0;
            match_n  = '0;
            state_n  = WAIT_EDGE;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
            hi_n  = hi_q + CNT_W'(div_in);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_monitor.sv
// tb_dcm_monitor: directed stimulus for dcm_monitor with a cycle-level
// behavioural model compared every cycle, plus literal spot checks.
module tb_dcm_monitor;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned LOCK_N = 2;
  localparam int TMO = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_in;
  logic [2:0]       prog;
  logic             update;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             err;

  dcm_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .prog(prog), .update(update),
    .period(period), .high_time(high_time), .valid(valid),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the cycle index of the reference rise and the
  // number of high cycles since it, and derives outputs from those.
  int HT[8] = '{0, 1, 2, 5, 8, 16, 32, 64};
  bit   mdl_ok = 0;
  int   cyc = 0;
  bit   m_prev, m_idle, m_ref;
  int   m_ref_cyc, m_ones, m_streak;
  logic [2:0] m_progq;
  logic [CNT_W-1:0] e_period, e_high;
  bit   e_valid, e_locked, e_err;

  always @(posedge clk) begin
    bit rise_m, resync_m;
    int el;
    cyc++;
    if (rst) begin
      m_prev = 0; m_progq = 3'd0; m_idle = 1; m_ref = 0; m_streak = 0; m_ones = 0;
      e_period = '0; e_high = '0; e_valid = 0; e_locked = 0; e_err = 0;
      mdl_ok = 1;
    end else begin
      rise_m   = div_in && !m_prev;
      resync_m = update || (prog != m_progq);
      e_valid  = 0;
      if (m_idle) begin
        e_locked = 0; e_err = 0; m_streak = 0;
        if (prog != 3'd0) begin m_idle = 0; m_ref = 0; end
      end else if (resync_m) begin
        e_locked = 0; e_err = 0; m_streak = 0; m_ref = 0;
        m_idle = (prog == 3'd0);
      end else if (rise_m) begin
        if (m_ref) begin
          el = cyc - m_ref_cyc;
          e_valid  = 1;
          e_period = CNT_W'(el);
          e_high   = CNT_W'(m_ones);
          if (el == 2 * HT[m_progq] && m_ones == HT[m_progq]) begin
            if (m_streak < LOCK_N) m_streak++;
            e_locked = (m_streak == LOCK_N);
          end else begin
            if (e_locked) e_err = 1;
            e_locked = 0; m_streak = 0;
          end
        end
        m_ref = 1; m_ref_cyc = cyc; m_ones = 1;
      end else if (m_ref) begin
        if (cyc - m_ref_cyc >= TMO) begin
          e_err = 1; e_locked = 0; m_streak = 0; m_ref = 0;
        end else begin
          m_ones += int'(div_in);
        end
      end
      m_prev  = div_in;
      m_progq = prog;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mdl_ok) begin
      check("valid",     32'(valid),     32'(e_valid));
      check("locked",    32'(locked),    32'(e_locked));
      check("err",       32'(err),       32'(e_err));
      check("period",    32'(period),    32'(e_period));
      check("high_time", 32'(high_time), 32'(e_high));
      check("valid_spacing", 32'(valid & prev_valid), 32'd0);
      prev_valid = valid;
      if (valid === 1'b1) vcount++;
    end
  end

  task automatic drive(input logic d, input logic [2:0] p, input logic u);
    @(negedge clk);
    div_in = d; prog = p; update = u;
  endtask

  task automatic wave(input int l, input int h, input logic [2:0] p);
    for (int i = 0; i < l; i++) drive(1'b0, p, 1'b0);
    for (int i = 0; i < h; i++) drive(1'b1, p, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    rst = 1'b1; div_in = 1'b0; prog = 3'd0; update = 1'b0;
    repeat (3) drive(1'b0, 3'd0, 1'b0);
    settle();
    check("rst_period", 32'(period), 32'd0);
    check("rst_high",   32'(high_time), 32'd0);
    check("rst_valid",  32'(valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;

    // prog=1, div toggling every cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd1, 1'b0);
      drive(1'b0, 3'd1, 1'b0);
    end
    settle();
    check("p1_period", 32'(period), 32'd2);
    check("p1_high",   32'(high_time), 32'd1);
    check("p1_locked", 32'(locked), 32'd1);
    check("p1_err",    32'(err), 32'd0);

    // prog=4, 8/8 then a stretched 9-high period
    repeat (4) wave(8, 8, 3'd4);
    settle();
    check("p4_period", 32'(period), 32'd16);
    check("p4_high",   32'(high_time), 32'd8);
    check("p4_locked", 32'(locked), 32'd1);
    wave(8, 9, 3'd4);
    wave(8, 8, 3'd4);
    settle();
    check("str_period", 32'(period), 32'd17);
    check("str_high",   32'(high_time), 32'd9);
    check("str_err",    32'(err), 32'd1);
    check("str_locked", 32'(locked), 32'd0);
    repeat (2) wave(8, 8, 3'd4);
    settle();
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_err",    32'(err), 32'd1);

    // prog=3 locked, then update coincident with a rise
    repeat (4) wave(5, 5, 3'd3);
    settle();
    check("p3_locked", 32'(locked), 32'd1);
    repeat (5) drive(1'b0, 3'd3, 1'b0);
    drive(1'b1, 3'd3, 1'b1);
    settle();
    check("upd_locked", 32'(locked), 32'd0);
    check("upd_err",    32'(err), 32'd0);
    repeat (4) drive(1'b1, 3'd3, 1'b0);
    v0 = vcount;
    wave(5, 5, 3'd3);
    settle();
    check("upd_first_rise_no_valid", 32'(vcount - v0), 32'd0);
    wave(5, 5, 3'd3);
    settle();
    check("upd_second_rise_valid", 32'(vcount - v0), 32'd1);
    check("upd_period", 32'(period), 32'd10);
    check("upd_high",   32'(high_time), 32'd5);

    // prog=7, divided clock stalls low
    v0 = vcount;
    wave(64, 64, 3'd7);
    repeat (950) drive(1'b0, 3'd7, 1'b0);
    settle();
    check("tmo_before_err", 32'(err), 32'd0);
    repeat (20) drive(1'b0, 3'd7, 1'b0);
    settle();
    check("tmo_err",      32'(err), 32'd1);
    check("tmo_no_valid", 32'(vcount - v0), 32'd0);
    drive(1'b0, 3'd6, 1'b0);
    settle();
    check("tmo_clear_err", 32'(err), 32'd0);

    // prog=0 bypass with toggling input
    v0 = vcount;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd0, 1'b0);
      drive(1'b0, 3'd0, 1'b0);
    end
    settle();
    check("byp_no_valid", 32'(vcount - v0), 32'd0);
    check("byp_period",   32'(period), 32'd10);
    check("byp_locked",   32'(locked), 32'd0);
    check("byp_err",      32'(err), 32'd0);

    // prog=5, reset mid-period
    repeat (3) wave(16, 16, 3'd5);
    repeat (5) drive(1'b0, 3'd5, 1'b0);
    @(negedge clk) rst = 1'b1;
    settle();
    check("mrst_period", 32'(period), 32'd0);
    check("mrst_high",   32'(high_time), 32'd0);
    check("mrst_valid",  32'(valid), 32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_err",    32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;
    v0 = vcount;
    wave(16, 16, 3'd5);
    settle();
    check("mrst_discard", 32'(vcount - v0), 32'd0);
    wave(16, 16, 3'd5);
    settle();
    check("mrst_valid_cnt", 32'(vcount - v0), 32'd1);
    check("mrst_p_period",  32'(period), 32'd32);
    check("mrst_p_high",    32'(high_time), 32'd16);

    repeat (4) drive(1'b0, 3'd5, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcm_monitor.md
# dcm_monitor

Receive-side checker for the programmable divided clock. It samples the divided clock as a data signal in the source clock domain and measures every period and high time in source-clock cycles. It compares the measurement against the period implied by the 3-bit program code and reports lock status and a sticky error. It sits beside the clock generator and watches its divided output, program code and update strobe.

## Interface
- CNT_W, 10: width of period/high-time counters; must be ≥ 8
- LOCK_N, 2: consecutive matching periods required to assert locked (1..15)

- clk  in  1  source clock; the divided clock is derived from it
- rst  in  1  synchronous, active-high reset
- div_in  in  1  divided clock, sampled as data on posedge clk
- prog  in  3  program code currently driving the generator
- update  in  1  one-cycle resync strobe issued to the generator
- period  out  CNT_W  last measured rise-to-rise period, in clk cycles
- high_time  out  CNT_W  clk cycles div_in was high in that period
- valid  out  1  one-cycle pulse: period/high_time just updated
- locked  out  1  LOCK_N consecutive periods matched the expected value
- err  out  1  sticky mismatch/timeout flag

## Operation
- Expected half period H(prog): 0→bypass, 1→1, 2→2, 3→5, 4→8, 5→16, 6→32, 7→64. Expected period = 2·H; expected high_time = H.
- Edge detect: d_q <= div_in; rise = div_in & ~d_q.
- prog_q holds the registered prog. A resync event is: update=1, or prog ≠ prog_q.
- State IDLE:
  - Entered on reset or when prog==0.
  - No measurement; valid=0, locked=0, err=0.
  - period and high_time hold their values.
  - Exits to WAIT_EDGE the cycle after prog≠0.
- State WAIT_EDGE:
  - Discards everything until the first rise.
  - On that rise: cnt<=1, hi<=1, go to MEASURE. No valid is issued.
- State MEASURE:
  - Each non-rise cycle: cnt<=cnt+1; hi<=hi+div_in.
  - On rise:
    - period<=cnt, high_time<=hi, valid<=1.
    - cnt<=1, hi<=1.
    - Compare cnt==2H and hi==H.
- Lock logic:
  - A match increments match_cnt, saturating at LOCK_N; locked=1 when match_cnt==LOCK_N.
  - A mismatch while locked sets err=1, clears locked, and sets match_cnt=0.
  - A mismatch while unlocked sets match_cnt=0 only; err is unchanged.
- Timeout: cnt reaching 2^CNT_W−1 without a rise sets err=1, clears locked and match_cnt, goes to WAIT_EDGE, and issues no valid.
- Resync event from any non-IDLE state:
  - Go to WAIT_EDGE.
  - Clear locked, err and match_cnt.
  - Capture prog_q.
  - If the new prog==0, go to IDLE instead.
- Arithmetic: cnt and hi are unsigned CNT_W-bit values. Compare against 2H zero-extended to CNT_W.

## Timing
- Reset values: period=0, high_time=0, valid=0, locked=0, err=0, state IDLE, match_cnt=0, d_q=0, prog_q=0.
- Latency:
  - valid, period and high_time update at the clock edge ending the cycle in which rise is seen.
  - locked and err update in the same cycle as valid.
- Simultaneous events:
  - Resync and rise in the same cycle: resync wins and the rise is discarded; the next rise starts measurement.
  - Timeout and resync in the same cycle: resync wins and err ends at 0.
  - rst wins over everything, including mid-measurement; state returns to IDLE next cycle.
- valid is never high on two consecutive cycles. Minimum valid spacing is 2 cycles (H=1).
- First valid after resync occurs at the second rise seen after the resync.

## Test plan
- prog=1 after reset, div_in toggling every cycle (1,0,1,0…):
  - valid pulses every 2 cycles with period=2, high_time=1.
  - locked=1 at the 2nd valid; err stays 0.
- prog=4, div_in 8 high/8 low, then one 9-high/8-low period:
  - Before the stretched period: locked=1, period=16, high_time=8.
  - At the stretched period's valid: period=17, high_time=9, err=1, locked=0.
  - Two further good periods re-lock; err stays 1.
- Locked at prog=3 (period 10), then update pulse in the same cycle as a rise:
  - locked=0, err=0 next cycle.
  - First valid arrives at the second subsequent rise, not the first.
- prog=7, div_in held 0 for 1023 cycles:
  - err=1 and state WAIT_EDGE at cnt=1023; no valid pulse.
  - Change prog to 6: err clears next cycle.
- prog=0 with div_in toggling:
  - valid, locked and err stay 0; period holds its prior value.
- Assert rst mid-period at prog=5:
  - All outputs 0 next cycle.
  - After release: one discarded rise, then period=32, high_time=16.
